// File: rtl/tim_pkg.sv
// Shared types and default widths for the timer time-base slice.
package tim_pkg;

  typedef enum logic [1:0] {
    EDGE    = 2'b00,
    CENTER1 = 2'b01,
    CENTER2 = 2'b10,
    CENTER3 = 2'b11
  } cms_e;

  localparam int unsigned DEF_CNT_WIDTH = 32;
  localparam int unsigned DEF_PSC_WIDTH = 16;
  localparam int unsigned DEF_RCR_WIDTH = 8;

endpackage

// File: rtl/tim_prescaler.sv
// Prescaler: divides the enabled clock by psc_sh+1 and emits a one-cycle tick.
module tim_prescaler
  import tim_pkg::*;
#(
  parameter int unsigned PSC_WIDTH = DEF_PSC_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 aresetn_i,
  input  logic                 en,
  input  logic                 load,
  input  logic [PSC_WIDTH-1:0] psc,
  output logic                 tick
);

  logic [PSC_WIDTH-1:0] pc;
  logic [PSC_WIDTH-1:0] psc_sh;

  assign tick = en & (pc == psc_sh);

  // An update event restarts the division with the freshly loaded ratio.
  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      pc     <= '0;
      psc_sh <= '0;
    end else if (load) begin
      pc     <= '0;
      psc_sh <= psc;
    end else if (en) begin
      pc <= tick ? '0 : pc + PSC_WIDTH'(1);
    end
  end

endmodule

// File: rtl/tim_time_base.sv
// Timer time base: prescaled up/down/center counter with repetition counter and update events.
module tim_time_base
  import tim_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH,
  parameter int unsigned PSC_WIDTH = DEF_PSC_WIDTH,
  parameter int unsigned RCR_WIDTH = DEF_RCR_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 aresetn_i,
  input  logic                 cen_i,
  input  logic                 udis_i,
  input  logic                 urs_i,
  input  logic                 opm_i,
  input  logic                 arpe_i,
  input  logic                 dir_cfg_i,
  input  logic [1:0]           cms_i,
  input  logic [PSC_WIDTH-1:0] psc_i,
  input  logic [CNT_WIDTH-1:0] arr_i,
  input  logic [RCR_WIDTH-1:0] rcr_i,
  input  logic                 ug_i,
  input  logic                 cnt_wr_i,
  input  logic [CNT_WIDTH-1:0] cnt_wdata_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 dir_o,
  output logic                 uev_o,
  output logic                 uif_set_o,
  output logic                 cen_clr_o
);

  cms_e                 cms;
  logic                 edge_mode;
  logic                 en;
  logic                 tick;
  logic                 flow;
  logic                 cuev;
  logic                 uev_d;
  logic                 uif_d;
  logic                 clr_d;
  logic                 halt_d;
  logic                 opm_halt;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic [CNT_WIDTH-1:0] arr_sh;
  logic                 dir_q;
  logic                 dir_d;
  logic [RCR_WIDTH-1:0] rep_q;
  logic [RCR_WIDTH-1:0] rep_d;
  logic                 uev_q;
  logic                 uif_q;
  logic                 clr_q;

  assign cms       = cms_e'(cms_i);
  assign edge_mode = (cms == EDGE);
  assign en        = cen_i & ~opm_halt;

  tim_prescaler #(
    .PSC_WIDTH(PSC_WIDTH)
  ) u_prescaler (
    .clk_i    (clk_i),
    .aresetn_i(aresetn_i),
    .en       (en),
    .load     (uev_d),
    .psc      (psc_i),
    .tick     (tick)
  );

  always_comb begin
    cnt_d = cnt_q;
    dir_d = edge_mode ? dir_cfg_i : dir_q;
    flow  = 1'b0;
    if (ug_i) begin
      cnt_d = (edge_mode && dir_cfg_i) ? arr_i : '0;
      if (!edge_mode) dir_d = 1'b0;
    end else if (cnt_wr_i) begin
      cnt_d = cnt_wdata_i;
    end else if (tick) begin
      if (arr_sh == '0) begin
        cnt_d = '0;
        flow  = 1'b1;
      end else if (edge_mode && !dir_cfg_i) begin
        if (cnt_q >= arr_sh) begin
          cnt_d = '0;
          flow  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end else if (edge_mode) begin
        if (cnt_q == '0) begin
          cnt_d = arr_sh;
          flow  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end else if (!dir_q) begin
        // Center mode turns around at arr_sh on the way up and at 0 on the way down.
        if (cnt_q >= arr_sh - CNT_WIDTH'(1)) begin
          cnt_d = arr_sh;
          flow  = 1'b1;
          dir_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end else begin
        if (cnt_q <= CNT_WIDTH'(1)) begin
          cnt_d = '0;
          flow  = 1'b1;
          dir_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end
    end
  end

  always_comb begin
    cuev  = flow & (rep_q == '0);
    uev_d = (cuev & ~udis_i) | ug_i;
    uif_d = uev_d & ~(ug_i & urs_i);
    clr_d = cuev & opm_i;

    rep_d = rep_q;
    if (uev_d || cuev) rep_d = rcr_i;
    else if (flow)     rep_d = rep_q - RCR_WIDTH'(1);

    halt_d = opm_halt;
    if (!cen_i)     halt_d = 1'b0;
    else if (clr_d) halt_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      cnt_q    <= '0;
      dir_q    <= 1'b0;
      rep_q    <= '0;
      arr_sh   <= '1;
      opm_halt <= 1'b0;
      uev_q    <= 1'b0;
      uif_q    <= 1'b0;
      clr_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      rep_q    <= rep_d;
      opm_halt <= halt_d;
      uev_q    <= uev_d;
      uif_q    <= uif_d;
      clr_q    <= clr_d;
      if (!arpe_i || uev_d) arr_sh <= arr_i;
    end
  end

  assign cnt_o     = cnt_q;
  assign dir_o     = dir_q;
  assign uev_o     = uev_q;
  assign uif_set_o = uif_q;
  assign cen_clr_o = clr_q;

endmodule

// File: tb/tb_tim_time_base.sv
// Directed, table-driven bench for tim_time_base.
module tb_tim_time_base;
  import tim_pkg::*;

  localparam int unsigned CW = 32;
  localparam int unsigned PW = 16;
  localparam int unsigned RW = 8;

  logic          clk_i = 1'b0;
  logic          aresetn_i;
  logic          cen_i, udis_i, urs_i, opm_i, arpe_i, dir_cfg_i;
  logic [1:0]    cms_i;
  logic [PW-1:0] psc_i;
  logic [CW-1:0] arr_i;
  logic [RW-1:0] rcr_i;
  logic          ug_i, cnt_wr_i;
  logic [CW-1:0] cnt_wdata_i;
  logic [CW-1:0] cnt_o;
  logic          dir_o, uev_o, uif_set_o, cen_clr_o;

  always #5 clk_i = ~clk_i;

  tim_time_base #(
    .CNT_WIDTH(CW),
    .PSC_WIDTH(PW),
    .RCR_WIDTH(RW)
  ) dut (
    .clk_i      (clk_i),
    .aresetn_i  (aresetn_i),
    .cen_i      (cen_i),
    .udis_i     (udis_i),
    .urs_i      (urs_i),
    .opm_i      (opm_i),
    .arpe_i     (arpe_i),
    .dir_cfg_i  (dir_cfg_i),
    .cms_i      (cms_i),
    .psc_i      (psc_i),
    .arr_i      (arr_i),
    .rcr_i      (rcr_i),
    .ug_i       (ug_i),
    .cnt_wr_i   (cnt_wr_i),
    .cnt_wdata_i(cnt_wdata_i),
    .cnt_o      (cnt_o),
    .dir_o      (dir_o),
    .uev_o      (uev_o),
    .uif_set_o  (uif_set_o),
    .cen_clr_o  (cen_clr_o)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          cen;
    logic          ug;
    logic [CW-1:0] cnt;
    logic          dir;
    logic          uev;
    logic          uif;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic cen, input logic ug, input int unsigned cnt,
                             input logic dir, input logic uev, input logic uif);
    vec_t r;
    r.cen = cen;
    r.ug  = ug;
    r.cnt = cnt;
    r.dir = dir;
    r.uev = uev;
    r.uif = uif;
    return r;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_v(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic exp_out(input string tag, input int unsigned cnt, input logic uev, input logic uif);
    chk_v({tag, ".cnt"}, cnt_o, CW'(cnt));
    chk_b({tag, ".uev"}, uev_o, uev);
    chk_b({tag, ".uif"}, uif_set_o, uif);
  endtask

  task automatic run_table(input string tag);
    for (int unsigned i = 0; i < tbl.size(); i++) begin
      cen_i = tbl[i].cen;
      ug_i  = tbl[i].ug;
      step();
      chk_v($sformatf("%s[%0d].cnt", tag, i), cnt_o, tbl[i].cnt);
      chk_b($sformatf("%s[%0d].dir", tag, i), dir_o, tbl[i].dir);
      chk_b($sformatf("%s[%0d].uev", tag, i), uev_o, tbl[i].uev);
      chk_b($sformatf("%s[%0d].uif", tag, i), uif_set_o, tbl[i].uif);
      chk_b($sformatf("%s[%0d].clr", tag, i), cen_clr_o, 1'b0);
    end
    ug_i = 1'b0;
    tbl.delete();
  endtask

  initial begin
    aresetn_i = 1'b0;
    cen_i = 1'b1; udis_i = 1'b0; urs_i = 1'b0; opm_i = 1'b0; arpe_i = 1'b0;
    dir_cfg_i = 1'b0; cms_i = EDGE; psc_i = '0; arr_i = '0; rcr_i = '0;
    ug_i = 1'b0; cnt_wr_i = 1'b0; cnt_wdata_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    exp_out("rst", 0, 1'b0, 1'b0);
    chk_b("rst.dir", dir_o, 1'b0);
    chk_b("rst.clr", cen_clr_o, 1'b0);
    @(negedge clk_i);
    aresetn_i = 1'b1;

    // Edge up, psc=1, arr=4: each count value lasts two clocks, wrap every 10.
    cen_i = 1'b0; psc_i = 16'd1; arr_i = 32'd4;
    tbl.push_back(v(0, 1, 0, 0, 1, 1));
    tbl.push_back(v(1, 0, 0, 0, 0, 0)); tbl.push_back(v(1, 0, 1, 0, 0, 0));
    tbl.push_back(v(1, 0, 1, 0, 0, 0)); tbl.push_back(v(1, 0, 2, 0, 0, 0));
    tbl.push_back(v(1, 0, 2, 0, 0, 0)); tbl.push_back(v(1, 0, 3, 0, 0, 0));
    tbl.push_back(v(1, 0, 3, 0, 0, 0)); tbl.push_back(v(1, 0, 4, 0, 0, 0));
    tbl.push_back(v(1, 0, 4, 0, 0, 0)); tbl.push_back(v(1, 0, 0, 0, 1, 1));
    tbl.push_back(v(1, 0, 0, 0, 0, 0)); tbl.push_back(v(1, 0, 1, 0, 0, 0));
    tbl.push_back(v(1, 0, 1, 0, 0, 0)); tbl.push_back(v(1, 0, 2, 0, 0, 0));
    tbl.push_back(v(1, 0, 2, 0, 0, 0)); tbl.push_back(v(1, 0, 3, 0, 0, 0));
    tbl.push_back(v(1, 0, 3, 0, 0, 0)); tbl.push_back(v(1, 0, 4, 0, 0, 0));
    tbl.push_back(v(1, 0, 4, 0, 0, 0)); tbl.push_back(v(1, 0, 0, 0, 1, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0)); tbl.push_back(v(0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 0, 0)); tbl.push_back(v(1, 0, 1, 0, 0, 0));
    run_table("up");

    // Center-aligned, arr=3, psc=0.
    cms_i = CENTER1; psc_i = '0; arr_i = 32'd3;
    tbl.push_back(v(1, 1, 0, 0, 1, 1));
    tbl.push_back(v(1, 0, 1, 0, 0, 0)); tbl.push_back(v(1, 0, 2, 0, 0, 0));
    tbl.push_back(v(1, 0, 3, 1, 1, 1)); tbl.push_back(v(1, 0, 2, 1, 0, 0));
    tbl.push_back(v(1, 0, 1, 1, 0, 0)); tbl.push_back(v(1, 0, 0, 0, 1, 1));
    tbl.push_back(v(1, 0, 1, 0, 0, 0)); tbl.push_back(v(1, 0, 2, 0, 0, 0));
    tbl.push_back(v(1, 0, 3, 1, 1, 1));
    run_table("ctr");

    // Edge down, arr=3, rcr=2: UEV only on every third underflow.
    cms_i = EDGE; dir_cfg_i = 1'b1; rcr_i = 8'd2;
    tbl.push_back(v(0, 1, 3, 1, 1, 1));
    for (int unsigned p = 0; p < 4; p++) begin
      tbl.push_back(v(1, 0, 2, 1, 0, 0));
      tbl.push_back(v(1, 0, 1, 1, 0, 0));
      tbl.push_back(v(1, 0, 0, 1, 0, 0));
      tbl.push_back(v(1, 0, 3, 1, (p == 2) ? 1'b1 : 1'b0, (p == 2) ? 1'b1 : 1'b0));
    end
    run_table("dn");

    // ARR preload: change mid-period takes effect only after the next wrap.
    dir_cfg_i = 1'b0; rcr_i = '0; arpe_i = 1'b1; arr_i = 32'd4; cen_i = 1'b0;
    ug_i = 1'b1; step(); ug_i = 1'b0;
    exp_out("arpe.ug", 0, 1'b1, 1'b1);
    cen_i = 1'b1;
    step(); exp_out("arpe.c1", 1, 1'b0, 1'b0);
    step(); exp_out("arpe.c2", 2, 1'b0, 1'b0);
    arr_i = 32'd7;
    step(); exp_out("arpe.c3", 3, 1'b0, 1'b0);
    step(); exp_out("arpe.c4", 4, 1'b0, 1'b0);
    step(); exp_out("arpe.wrap4", 0, 1'b1, 1'b1);
    for (int unsigned k = 1; k <= 7; k++) begin
      step(); exp_out($sformatf("arpe.p2[%0d]", k), k, 1'b0, 1'b0);
    end
    step(); exp_out("arpe.wrap7", 0, 1'b1, 1'b1);

    // Software update with urs=1, coincident with a prescaler tick.
    urs_i = 1'b1;
    step(); exp_out("urs.c1", 1, 1'b0, 1'b0);
    step(); exp_out("urs.c2", 2, 1'b0, 1'b0);
    ug_i = 1'b1; step(); ug_i = 1'b0;
    exp_out("urs.ug", 0, 1'b1, 1'b0);
    step(); exp_out("urs.after", 1, 1'b0, 1'b0);
    for (int unsigned k = 2; k <= 7; k++) begin
      step(); exp_out($sformatf("urs.run[%0d]", k), k, 1'b0, 1'b0);
    end
    step(); exp_out("urs.ovf", 0, 1'b1, 1'b1);

    // One-pulse mode, arr=2.
    urs_i = 1'b0; arpe_i = 1'b0; opm_i = 1'b1; arr_i = 32'd2; cen_i = 1'b0;
    ug_i = 1'b1; step(); ug_i = 1'b0;
    exp_out("opm.ug", 0, 1'b1, 1'b1);
    chk_b("opm.ug.clr", cen_clr_o, 1'b0);
    cen_i = 1'b1;
    step(); exp_out("opm.c1", 1, 1'b0, 1'b0);
    step(); exp_out("opm.c2", 2, 1'b0, 1'b0);
    step(); exp_out("opm.end", 0, 1'b1, 1'b1);
    chk_b("opm.end.clr", cen_clr_o, 1'b1);
    step(); exp_out("opm.hold1", 0, 1'b0, 1'b0);
    chk_b("opm.hold1.clr", cen_clr_o, 1'b0);
    step(); exp_out("opm.hold2", 0, 1'b0, 1'b0);
    cen_i = 1'b0;
    step(); exp_out("opm.cen0", 0, 1'b0, 1'b0);
    cen_i = 1'b1; opm_i = 1'b0;
    step(); exp_out("opm.restart", 1, 1'b0, 1'b0);

    // Update disable suppresses the counter UEV but not the wrap.
    udis_i = 1'b1;
    step(); exp_out("udis.c2", 2, 1'b0, 1'b0);
    step(); exp_out("udis.wrap", 0, 1'b0, 1'b0);
    step(); exp_out("udis.c1", 1, 1'b0, 1'b0);
    udis_i = 1'b0;

    // Direct counter write overrides the tick.
    cnt_wr_i = 1'b1; cnt_wdata_i = 32'd2;
    step(); exp_out("wr.load", 2, 1'b0, 1'b0);
    cnt_wr_i = 1'b0;
    step(); exp_out("wr.wrap", 0, 1'b1, 1'b1);

    // arr=0: counter pinned at 0, every tick is an overflow.
    arr_i = '0;
    step(); exp_out("arr0.c1", 1, 1'b0, 1'b0);
    step(); exp_out("arr0.t1", 0, 1'b1, 1'b1);
    step(); exp_out("arr0.t2", 0, 1'b1, 1'b1);

    // Reset asserted mid-count restarts from reset values without a UEV.
    arr_i = 32'd5;
    step(); exp_out("rr.t", 0, 1'b1, 1'b1);
    step(); exp_out("rr.c1", 1, 1'b0, 1'b0);
    step(); exp_out("rr.c2", 2, 1'b0, 1'b0);
    #2 aresetn_i = 1'b0;
    #1;
    exp_out("rr.rst", 0, 1'b0, 1'b0);
    @(negedge clk_i);
    aresetn_i = 1'b1;
    step(); exp_out("rr.post1", 1, 1'b0, 1'b0);
    step(); exp_out("rr.post2", 2, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
